mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the address and data paths; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 MemReadM  input  1  load request from the execute/memory pipeline register.
REQ-005 MemWriteM  input  1  store request from the execute/memory pipeline register.
REQ-006 AddrModeM  input  1  access size: 0 = word, 1 = byte.
REQ-007 ALUResultM  input  DATA_WIDTH  byte address of the access.
REQ-008 WriteDataM  input  DATA_WIDTH  store data; byte stores use bits [7:0].
REQ-009 StallM  output  1  freezes the pipeline while an access is outstanding.
REQ-010 ReadDataM  output  DATA_WIDTH  load result; byte loads are zero-extended.
REQ-011 ReadValidM  output  1  one-cycle pulse when ReadDataM is updated.
REQ-012 MisalignM  output  1  one-cycle pulse on a rejected misaligned word access.
REQ-013 mem_req_valid  output  1  memory request valid.
REQ-014 mem_req_ready  input  1  memory accepts the request.
REQ-015 mem_we  output  1  1 = write, 0 = read.
REQ-016 mem_addr  output  DATA_WIDTH  word-aligned address; bits [1:0] are always 00.
REQ-017 mem_wdata  output  DATA_WIDTH  write data.
REQ-018 mem_be  output  4  byte enables.
REQ-019 mem_rsp_valid  input  1  read data is valid.
REQ-020 mem_rdata  input  DATA_WIDTH  read data.

Function
REQ-021 The unit SHALL implement a state machine with states IDLE, REQ, WAIT, DONE.
REQ-022 IDLE: when MemReadM or MemWriteM is set, the unit SHALL latch the address, data, size and direction, and move to REQ on the next edge.
REQ-023 IDLE: StallM SHALL be driven combinationally high in the same cycle a request is present.
REQ-024 REQ: mem_req_valid SHALL be 1 and all request fields SHALL be held stable until mem_req_ready=1.
REQ-025 REQ: on the handshake, a write SHALL go to DONE and a read SHALL go to WAIT.
REQ-026 WAIT: on mem_rsp_valid=1 the unit SHALL capture the selected data and move to DONE.
REQ-027 StallM SHALL be 1 in REQ and WAIT and 0 in DONE, so the pipeline advances exactly once per access.
REQ-028 DONE SHALL last one cycle and then return to IDLE.
REQ-029 ReadValidM SHALL pulse in DONE for reads only.
REQ-030 Minimum latency: a write with ready already high takes 2 stall cycles; a read with an immediate response takes 3.
REQ-031 Word access: mem_be SHALL be 4'hF and ReadDataM SHALL be mem_rdata.
REQ-032 Byte access: mem_be SHALL be 1<<addr[1:0], and mem_wdata SHALL replicate WriteDataM[7:0] into all four lanes.
REQ-033 Byte read: ReadDataM SHALL be {24'b0, lane addr[1:0] of mem_rdata}, using the latched address.
REQ-034 MemReadM and MemWriteM both high: the access SHALL be performed as a write only.
REQ-035 mem_rsp_valid SHALL be ignored outside WAIT.
REQ-036 mem_req_ready SHALL be ignored outside REQ.
REQ-037 ReadDataM SHALL hold its value until the next completed read.

Reset
REQ-038 With rst_n=0 the unit SHALL immediately enter IDLE, even mid-transaction.
REQ-039 Reset values: mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, ReadDataM=0, ReadValidM=0, MisalignM=0.
REQ-040 StallM SHALL follow REQ-023 once rst_n is released.
REQ-041 A response arriving after reset SHALL be discarded.

Configuration
REQ-042 Macro MEM_MISALIGN_CHECK_EN SHALL be defined: a word access with addr[1:0]!=00 SHALL issue no memory request.
REQ-043 In that case the unit SHALL go IDLE->DONE, pulse MisalignM, and leave ReadDataM unchanged.
REQ-044 Macro MEM_MISALIGN_CHECK_EN SHALL be undefined: MisalignM SHALL be tied 0 and addr[1:0] SHALL be dropped on word accesses.

Verification
REQ-045 Word write to 0x100 of 0xDEADBEEF, ready high -> mem_addr=0x100, be=F, wdata=0xDEADBEEF, StallM high for 2 cycles.
REQ-046 Byte read at 0x103, mem_rdata=0xA1B2C3D4 after 3 wait cycles -> ReadDataM=0x000000A1, ReadValidM pulses once.
REQ-047 Byte write 0x55 at 0x202, ready delayed 4 cycles -> be=4'b0100, wdata=0x55555555, request fields stable throughout.
REQ-048 rst_n low during WAIT, then a stale mem_rsp_valid -> state is IDLE, ReadDataM=0, no ReadValidM.
REQ-049 With MEM_MISALIGN_CHECK_EN defined, word read at 0x302 -> no mem_req_valid, MisalignM pulses; without the macro -> read at 0x300.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Memory-side request/response bus of mem_access_unit.
// The unit drives the master side; the memory (or a bench model) takes the slave side.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Pipeline memory-stage access unit: stalls the pipe while one load/store runs on the memory bus.
// Optional macro MEM_MISALIGN_CHECK_EN rejects misaligned word accesses without touching the bus.
//
// state | meaning
// IDLE  | no access; request fields latched when MemReadM/MemWriteM appear
// REQ   | mem_req_valid high, fields held until mem_req_ready
// WAIT  | read accepted, waiting for mem_rsp_valid
// DONE  | one cycle, StallM low so the pipeline advances once
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic                  AddrModeM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  ReadValidM,
  output logic                  MisalignM,
  mem_access_unit_if.master     mem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state, state_nx;
  logic                  req;
  logic                  misalign;
  logic                  mis_q;
  logic                  we_q;
  logic                  byte_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            be_q;
  logic [7:0]            lane;

  assign req = MemReadM | MemWriteM;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = ~AddrModeM & (ALUResultM[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (state == IDLE && req) begin
      mis_q <= misalign;
    end
  end

  assign MisalignM = (state == DONE) & mis_q;
`else
  assign misalign  = 1'b0;
  assign mis_q     = 1'b0;
  assign MisalignM = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    StallM   = 1'b0;
    case (state)
      IDLE: begin
        StallM = req;
        if (req) state_nx = misalign ? DONE : REQ;
      end
      REQ: begin
        StallM = 1'b1;
        if (mem.mem_req_ready) state_nx = we_q ? DONE : WAIT;
      end
      WAIT: begin
        StallM = 1'b1;
        if (mem.mem_rsp_valid) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lane = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane = mem.mem_rdata[7:0];
      2'd1:    lane = mem.mem_rdata[15:8];
      2'd2:    lane = mem.mem_rdata[23:16];
      default: lane = mem.mem_rdata[31:24];
    endcase
  end

  // Write beats wins when both MemReadM and MemWriteM are set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'h0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && req) begin
        we_q    <= MemWriteM;
        byte_q  <= AddrModeM;
        addr_q  <= ALUResultM;
        be_q    <= AddrModeM ? (4'b0001 << ALUResultM[1:0]) : 4'hF;
        wdata_q <= AddrModeM ? {4{WriteDataM[7:0]}} : WriteDataM;
      end
      if (state == WAIT && mem.mem_rsp_valid) begin
        rdata_q <= byte_q ? {{(DATA_WIDTH-8){1'b0}}, lane} : mem.mem_rdata;
      end
    end
  end

  assign mem.mem_req_valid = (state == REQ);
  assign mem.mem_we        = we_q;
  assign mem.mem_addr      = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_be        = be_q;
  assign ReadDataM         = rdata_q;
  assign ReadValidM        = (state == DONE) & ~we_q & ~mis_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: each task drives one scenario and checks hand-computed results.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM, AddrModeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, ReadValidM, MisalignM;
  logic [31:0] ReadDataM;
  int          tests_run = 0;
  int          tests_failed = 0;

  mem_access_unit_if #(.DATA_WIDTH(32)) mem ();

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AddrModeM(AddrModeM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataM(ReadDataM), .ReadValidM(ReadValidM), .MisalignM(MisalignM),
    .mem(mem)
  );

  always #5 clk = ~clk;

  // Drives one access and records what the bus and pipeline outputs did.
  task automatic do_access(input logic rd, input logic wr, input logic mode,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                           output int stalls, output int rv, output int mis, output int reqc,
                           output bit stable, output bit tmo,
                           output logic [31:0] a_seen, output logic [31:0] d_seen,
                           output logic [3:0] be_seen, output logic we_seen);
    bit acc, done;
    int wc;
    stalls = 0; rv = 0; mis = 0; reqc = 0; stable = 1'b1; tmo = 1'b1;
    a_seen = '0; d_seen = '0; be_seen = '0; we_seen = 1'b0;
    acc = 1'b0; done = 1'b0; wc = 0;
    MemReadM = rd; MemWriteM = wr; AddrModeM = mode; ALUResultM = addr; WriteDataM = wd;
    mem.mem_rdata = rdata;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (StallM) stalls++;
      if (ReadValidM) rv++;
      if (MisalignM) mis++;
      if (mem.mem_req_valid) begin
        if (reqc == 0) begin
          a_seen = mem.mem_addr; d_seen = mem.mem_wdata; be_seen = mem.mem_be; we_seen = mem.mem_we;
        end else if (mem.mem_addr !== a_seen || mem.mem_wdata !== d_seen ||
                     mem.mem_be !== be_seen || mem.mem_we !== we_seen) begin
          stable = 1'b0;
        end
        reqc++;
      end
      if (acc && StallM) begin
        wc++;
        mem.mem_rsp_valid = (wc > rsp_dly);
      end else begin
        mem.mem_rsp_valid = 1'b0;
      end
      if (!StallM && cyc > 0) begin
        done = 1'b1; tmo = 1'b0;
      end
      mem.mem_req_ready = mem.mem_req_valid && (reqc > rdy_dly);
      if (mem.mem_req_valid && mem.mem_req_ready) acc = 1'b1;
      if (!done) @(posedge clk);
    end
    mem.mem_req_ready = 1'b0; mem.mem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    #1;
    if (ReadValidM) rv++;
    if (MisalignM) mis++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    MemReadM = 0; MemWriteM = 0; AddrModeM = 0; ALUResultM = '0; WriteDataM = '0;
    mem.mem_req_ready = 0; mem.mem_rsp_valid = 0; mem.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #2;
    tests_run++; if (mem.mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_req_valid got %b exp 0", mem.mem_req_valid); end
    tests_run++; if (mem.mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_we got %b exp 0", mem.mem_we); end
    tests_run++; if (mem.mem_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_addr got %h exp 0", mem.mem_addr); end
    tests_run++; if (mem.mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL rst_wdata got %h exp 0", mem.mem_wdata); end
    tests_run++; if (mem.mem_be !== 4'h0) begin tests_failed++; $display("FAIL rst_be got %h exp 0", mem.mem_be); end
    tests_run++; if (ReadDataM !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata got %h exp 0", ReadDataM); end
    tests_run++; if (ReadValidM !== 1'b0 || MisalignM !== 1'b0) begin tests_failed++; $display("FAIL rst_pulses got rv=%b mis=%b exp 0 0", ReadValidM, MisalignM); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    tests_run++; if (StallM !== 1'b0) begin tests_failed++; $display("FAIL rst_stall_idle got %b exp 0", StallM); end
    MemReadM = 1'b1;
    #1;
    tests_run++; if (StallM !== 1'b1) begin tests_failed++; $display("FAIL idle_comb_stall got %b exp 1", StallM); end
    MemReadM = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ignore();
    mem.mem_req_ready = 1'b1; mem.mem_rsp_valid = 1'b1; mem.mem_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (mem.mem_req_valid !== 1'b0 || StallM !== 1'b0 || ReadValidM !== 1'b0) begin
        tests_failed++; $display("FAIL idle_ignore cyc%0d got valid=%b stall=%b rv=%b exp 0 0 0", i, mem.mem_req_valid, StallM, ReadValidM);
      end
      @(posedge clk); #1;
    end
    tests_run++; if (ReadDataM !== 32'h0) begin tests_failed++; $display("FAIL idle_ignore_rdata got %h exp 0", ReadDataM); end
    mem.mem_req_ready = 1'b0; mem.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_word_write();
    int s, rv, mis, rq; bit st, tmo; logic [31:0] a, d; logic [3:0] be; logic we;
    do_access(0, 1, 0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, s, rv, mis, rq, st, tmo, a, d, be, we);
    tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL ww_timeout got %b exp 0", tmo); end
    tests_run++; if (s !== 2) begin tests_failed++; $display("FAIL ww_stalls got %0d exp 2", s); end
    tests_run++; if (a !== 32'h100 || be !== 4'hF || we !== 1'b1) begin tests_failed++; $display("FAIL ww_fields got a=%h be=%h we=%b exp 100 f 1", a, be, we); end
    tests_run++; if (d !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL ww_wdata got %h exp deadbeef", d); end
    tests_run++; if (rv !== 0 || rq !== 1) begin tests_failed++; $display("FAIL ww_rv_reqc got rv=%0d reqc=%0d exp 0 1", rv, rq); end
  endtask

  task automatic test_byte_read();
    int s, rv, mis, rq; bit st, tmo; logic [31:0] a, d; logic [3:0] be; logic we;
    do_access(1, 0, 1, 32'h103, 32'h0, 0, 3, 32'hA1B2C3D4, s, rv, mis, rq, st, tmo, a, d, be, we);
    tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL br_timeout got %b exp 0", tmo); end
    tests_run++; if (s !== 6) begin tests_failed++; $display("FAIL br_stalls got %0d exp 6", s); end
    tests_run++; if (ReadDataM !== 32'h000000A1) begin tests_failed++; $display("FAIL br_rdata got %h exp 000000a1", ReadDataM); end
    tests_run++; if (rv !== 1) begin tests_failed++; $display("FAIL br_rv_pulses got %0d exp 1", rv); end
    tests_run++; if (a !== 32'h100 || be !== 4'b1000 || we !== 1'b0) begin tests_failed++; $display("FAIL br_fields got a=%h be=%b we=%b exp 100 1000 0", a, be, we); end
  endtask

  task automatic test_byte_write_delayed();
    int s, rv, mis, rq; bit st, tmo; logic [31:0] a, d; logic [3:0] be; logic we;
    do_access(0, 1, 1, 32'h202, 32'hFFFFFF55, 4, 0, 32'h0, s, rv, mis, rq, st, tmo, a, d, be, we);
    tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL bw_timeout got %b exp 0", tmo); end
    tests_run++; if (s !== 6 || rq !== 5) begin tests_failed++; $display("FAIL bw_cycles got stalls=%0d reqc=%0d exp 6 5", s, rq); end
    tests_run++; if (be !== 4'b0100 || a !== 32'h200) begin tests_failed++; $display("FAIL bw_fields got be=%b a=%h exp 0100 200", be, a); end
    tests_run++; if (d !== 32'h55555555) begin tests_failed++; $display("FAIL bw_wdata got %h exp 55555555", d); end
    tests_run++; if (st !== 1'b1) begin tests_failed++; $display("FAIL bw_stable got %b exp 1", st); end
    tests_run++; if (ReadDataM !== 32'h000000A1) begin tests_failed++; $display("FAIL bw_rdata_hold got %h exp 000000a1", ReadDataM); end
  endtask

  task automatic test_read_write_both();
    int s, rv, mis, rq; bit st, tmo; logic [31:0] a, d; logic [3:0] be; logic we;
    do_access(1, 1, 0, 32'h40, 32'h12345678, 0, 0, 32'hFFFFFFFF, s, rv, mis, rq, st, tmo, a, d, be, we);
    tests_run++; if (we !== 1'b1 || s !== 2 || rv !== 0) begin tests_failed++; $display("FAIL both_write got we=%b stalls=%0d rv=%0d exp 1 2 0", we, s, rv); end
    tests_run++; if (d !== 32'h12345678 || ReadDataM !== 32'h000000A1) begin tests_failed++; $display("FAIL both_data got wdata=%h rdata=%h exp 12345678 000000a1", d, ReadDataM); end
  endtask

  task automatic test_word_read();
    int s, rv, mis, rq; bit st, tmo; logic [31:0] a, d; logic [3:0] be; logic we;
    do_access(1, 0, 0, 32'h104, 32'h0, 0, 1, 32'h0BADF00D, s, rv, mis, rq, st, tmo, a, d, be, we);
    tests_run++; if (tmo !== 1'b0 || s !== 4) begin tests_failed++; $display("FAIL wr_stalls got %0d tmo=%b exp 4 0", s, tmo); end
    tests_run++; if (ReadDataM !== 32'h0BADF00D || rv !== 1) begin tests_failed++; $display("FAIL wr_rdata got %h rv=%0d exp 0badf00d 1", ReadDataM, rv); end
    tests_run++; if (a !== 32'h104 || be !== 4'hF) begin tests_failed++; $display("FAIL wr_fields got a=%h be=%h exp 104 f", a, be); end
    do_access(1, 0, 1, 32'h200, 32'h0, 1, 0, 32'hA1B2C3D4, s, rv, mis, rq, st, tmo, a, d, be, we);
    tests_run++; if (s !== 4 || ReadDataM !== 32'h000000D4) begin tests_failed++; $display("FAIL br0 got stalls=%0d rdata=%h exp 4 000000d4", s, ReadDataM); end
    tests_run++; if (be !== 4'b0001) begin tests_failed++; $display("FAIL br0_be got %b exp 0001", be); end
  endtask

  task automatic test_misalign();
    int s, rv, mis, rq; bit st, tmo; logic [31:0] a, d; logic [3:0] be; logic we;
    do_access(1, 0, 0, 32'h302, 32'h0, 0, 0, 32'hCAFEF00D, s, rv, mis, rq, st, tmo, a, d, be, we);
    tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL mis_timeout got %b exp 0", tmo); end
`ifdef MEM_MISALIGN_CHECK_EN
    tests_run++; if (rq !== 0 || s !== 1) begin tests_failed++; $display("FAIL mis_noreq got reqc=%0d stalls=%0d exp 0 1", rq, s); end
    tests_run++; if (mis !== 1 || rv !== 0) begin tests_failed++; $display("FAIL mis_pulse got mis=%0d rv=%0d exp 1 0", mis, rv); end
    tests_run++; if (ReadDataM !== 32'h000000D4) begin tests_failed++; $display("FAIL mis_rdata_hold got %h exp 000000d4", ReadDataM); end
`else
    tests_run++; if (rq !== 1 || a !== 32'h300 || be !== 4'hF) begin tests_failed++; $display("FAIL mis_drop got reqc=%0d a=%h be=%h exp 1 300 f", rq, a, be); end
    tests_run++; if (mis !== 0 || rv !== 1) begin tests_failed++; $display("FAIL mis_pulse got mis=%0d rv=%0d exp 0 1", mis, rv); end
    tests_run++; if (ReadDataM !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL mis_rdata got %h exp cafef00d", ReadDataM); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    bit bad_rv;
    MemReadM = 1'b1; MemWriteM = 1'b0; AddrModeM = 1'b0; ALUResultM = 32'h400;
    mem.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem.mem_req_ready = 1'b0;
    #1;
    tests_run++; if (StallM !== 1'b1 || mem.mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rmw_in_wait got stall=%b valid=%b exp 1 0", StallM, mem.mem_req_valid); end
    MemReadM = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++; if (StallM !== 1'b0 || ReadDataM !== 32'h0 || mem.mem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL rmw_async got stall=%b rdata=%h addr=%h exp 0 0 0", StallM, ReadDataM, mem.mem_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem.mem_rsp_valid = 1'b1; mem.mem_rdata = 32'hFFFF0000;
    bad_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ReadValidM !== 1'b0 || StallM !== 1'b0 || mem.mem_req_valid !== 1'b0) bad_rv = 1'b1;
    end
    tests_run++; if (bad_rv !== 1'b0) begin tests_failed++; $display("FAIL rmw_stale_rsp got activity=%b exp 0", bad_rv); end
    tests_run++; if (ReadDataM !== 32'h0) begin tests_failed++; $display("FAIL rmw_rdata got %h exp 0", ReadDataM); end
    mem.mem_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_word_write();
    test_byte_read();
    test_byte_write_delayed();
    test_read_write_both();
    test_word_read();
    test_misalign();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
